// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: turns one register request into an address frame and a
// data frame for the downstream SPI master, tracks frame progress through the
// master's chip select, captures read data and returns a single response.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// A_CMD   | wait for CS high, then hold spi_wr_cmd for CMD_HOLD cycles
// A_START | address frame commanded, waiting for CS low
// A_END   | address frame running, waiting for CS high
// GAP1    | inter-frame gap, load write data onto mosi
// D_CMD   | wait for CS high, then hold wr/rd command for CMD_HOLD cycles
// D_START | data frame commanded, waiting for CS low
// D_END   | data frame running, waiting for CS high (read data sampled here)
// RESP    | response presented until rsp_ready
// GAP2    | post-transaction gap before returning to IDLE
module spi_reg_sequencer #(
    parameter int SPI_WIDTH = 8,
    parameter int CMD_HOLD  = 2,
    parameter int GAP_CYC   = 4,
    parameter int START_TO  = 16,
    parameter int END_TO    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_rw_i,
    input  logic [6:0]           req_addr_i,
    input  logic [SPI_WIDTH-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [SPI_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 spi_wr_cmd_o,
    output logic                 spi_rd_cmd_o,
    output logic [SPI_WIDTH-1:0] mosi_data_o,
    input  logic [SPI_WIDTH-1:0] miso_data_i,
    input  logic                 spi_cs_i
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] A_CMD   = 4'd1;
    localparam logic [3:0] A_START = 4'd2;
    localparam logic [3:0] A_END   = 4'd3;
    localparam logic [3:0] GAP1    = 4'd4;
    localparam logic [3:0] D_CMD   = 4'd5;
    localparam logic [3:0] D_START = 4'd6;
    localparam logic [3:0] D_END   = 4'd7;
    localparam logic [3:0] RESP    = 4'd8;
    localparam logic [3:0] GAP2    = 4'd9;

    localparam logic [7:0]  HOLD_LD    = 8'(CMD_HOLD - 1);
    localparam logic [7:0]  GAP_LD     = 8'(GAP_CYC - 1);
    localparam logic [15:0] START_TO_C = 16'(START_TO);
    localparam logic [15:0] END_TO_C   = 16'(END_TO);

    logic [3:0]           state_q, state_d;
    logic                 rw_q, rw_d;
    logic [SPI_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]          to_q, to_d;
    logic [7:0]           tmr_q, tmr_d;
    logic                 wr_cmd_q, wr_cmd_d;
    logic                 rd_cmd_q, rd_cmd_d;
    logic [SPI_WIDTH-1:0] mosi_q, mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [SPI_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [15:0]          to_inc;

    // Timeout counter counts cycles since the last tracked event and saturates.
    assign to_inc = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;

    // Next-state and next-output decode for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        to_d        = to_q;
        tmr_d       = tmr_q;
        wr_cmd_d    = wr_cmd_q;
        rd_cmd_d    = rd_cmd_q;
        mosi_d      = mosi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rw_d    = req_rw_i;
                    wdata_d = req_wdata_i;
                    mosi_d  = {req_rw_i, req_addr_i};
                    to_d    = 16'd0;
                    state_d = A_CMD;
                end
            end
            A_CMD, D_CMD: begin
                if (!wr_cmd_q && !rd_cmd_q) begin
                    // never start a frame while the master still holds CS low
                    if (spi_cs_i) begin
                        if (state_q == D_CMD && rw_q) begin
                            rd_cmd_d = 1'b1;
                        end else begin
                            wr_cmd_d = 1'b1;
                        end
                        tmr_d = HOLD_LD;
                        to_d  = 16'd1;
                    end
                end else begin
                    to_d = to_inc;
                    if (tmr_q == 8'd0) begin
                        wr_cmd_d = 1'b0;
                        rd_cmd_d = 1'b0;
                        state_d  = (state_q == A_CMD) ? A_START : D_START;
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end
            end
            A_START, D_START: begin
                if (!spi_cs_i) begin
                    to_d    = 16'd1;
                    state_d = (state_q == A_START) ? A_END : D_END;
                end else if (to_q >= START_TO_C) begin
                    wr_cmd_d    = 1'b0;
                    rd_cmd_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    to_d = to_inc;
                end
            end
            A_END, D_END: begin
                if (spi_cs_i) begin
                    if (state_q == A_END) begin
                        if (!rw_q) begin
                            mosi_d = wdata_q;
                        end
                        tmr_d   = GAP_LD;
                        state_d = GAP1;
                    end else begin
                        rsp_rdata_d = rw_q ? miso_data_i : '0;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else if (to_q >= END_TO_C) begin
                    wr_cmd_d    = 1'b0;
                    rd_cmd_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    to_d = to_inc;
                end
            end
            GAP1, GAP2: begin
                if (tmr_q == 8'd0) begin
                    state_d = (state_q == GAP1) ? D_CMD : IDLE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    tmr_d       = GAP_LD;
                    state_d     = GAP2;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            to_q        <= 16'd0;
            tmr_q       <= 8'd0;
            wr_cmd_q    <= 1'b0;
            rd_cmd_q    <= 1'b0;
            mosi_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            to_q        <= to_d;
            tmr_q       <= tmr_d;
            wr_cmd_q    <= wr_cmd_d;
            rd_cmd_q    <= rd_cmd_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign spi_wr_cmd_o = wr_cmd_q;
    assign spi_rd_cmd_o = rd_cmd_q;
    assign mosi_data_o  = mosi_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: a behavioural SPI master answers commands by
// pulling CS low for a fixed frame length; expected frames and responses are
// queued by the stimulus and consumed by independent monitors.
module tb_spi_reg_sequencer;

    localparam int CMD_HOLD  = 2;
    localparam int GAP_CYC   = 4;
    localparam int START_TO  = 16;
    localparam int END_TO    = 4096;
    localparam int FRAME_LEN = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       spi_wr_cmd, spi_rd_cmd, spi_cs;
    logic [7:0] mosi_data, miso_data;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_frames[$];   // {is_read_frame, mosi}
    logic [8:0] exp_rsp[$];      // {err, rdata}
    logic       master_en = 1'b1;
    logic [7:0] slave_val = 8'h00;

    always #5 clk = ~clk;

    spi_reg_sequencer #(
        .SPI_WIDTH(8), .CMD_HOLD(CMD_HOLD), .GAP_CYC(GAP_CYC),
        .START_TO(START_TO), .END_TO(END_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .spi_wr_cmd_o(spi_wr_cmd), .spi_rd_cmd_o(spi_rd_cmd),
        .mosi_data_o(mosi_data), .miso_data_i(miso_data), .spi_cs_i(spi_cs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        int n;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("return_to_idle", 32'(busy), 0);
    endtask

    // Behavioural SPI master: CS low a few cycles after a command, for FRAME_LEN cycles.
    initial begin
        spi_cs    = 1'b1;
        miso_data = 8'h00;
        forever begin
            @(negedge clk);
            if (master_en && (spi_wr_cmd || spi_rd_cmd)) begin
                repeat (3) @(negedge clk);
                spi_cs = 1'b0;
                repeat (FRAME_LEN) @(negedge clk);
                miso_data = slave_val;
                spi_cs    = 1'b1;
            end
        end
    end

    // Frame monitor: frame order/content, command width, gap before each command.
    initial begin
        int         cmd_len;
        int         low_cnt;
        logic       prev_cmd;
        logic       cmd_now;
        logic [8:0] f;
        cmd_len  = 0;
        low_cnt  = GAP_CYC;
        prev_cmd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_now = spi_wr_cmd || spi_rd_cmd;
            if (cmd_now) begin
                check("cmd_exclusive", 32'(spi_wr_cmd & spi_rd_cmd), 0);
            end
            if (cmd_now && !prev_cmd) begin
                check("gap_before_cmd", 32'(low_cnt >= GAP_CYC), 1);
                check("cs_high_at_cmd", 32'(spi_cs), 1);
                if (exp_frames.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got rd=%0b mosi=0x%0h, required no frame",
                             spi_rd_cmd, mosi_data);
                end else begin
                    f = exp_frames.pop_front();
                    check("frame", 32'({spi_rd_cmd, mosi_data}), 32'(f));
                end
            end
            if (cmd_now) begin
                cmd_len++;
            end else if (cmd_len > 0) begin
                check("cmd_hold", 32'(cmd_len), CMD_HOLD);
                cmd_len = 0;
            end
            if (cmd_now || !spi_cs) low_cnt = 0;
            else low_cnt++;
            prev_cmd = cmd_now;
        end
    end

    // Response monitor: pops the expected response on every handshake.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got err=%0b rdata=0x%0h, required no response",
                             rsp_err, rsp_rdata);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp", 32'({rsp_err, rsp_rdata}), 32'(e));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = 7'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_wr_cmd", 32'(spi_wr_cmd), 0);
        check("rst_rd_cmd", 32'(spi_rd_cmd), 0);
        check("rst_mosi", 32'(mosi_data), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);

        // write 0x15 to 0x2A
        exp_frames.push_back({1'b0, 8'h2A});
        exp_frames.push_back({1'b0, 8'h15});
        exp_rsp.push_back({1'b0, 8'h00});
        do_req(1'b0, 7'h2A, 8'h15);
        wait_idle();

        // read 0x2A, slave returns 0xC3
        slave_val = 8'hC3;
        exp_frames.push_back({1'b0, 8'hAA});
        exp_frames.push_back({1'b1, 8'hAA});
        exp_rsp.push_back({1'b0, 8'hC3});
        do_req(1'b1, 7'h2A, 8'h00);
        wait_idle();

        // response backpressure with a second request waiting
        rsp_ready = 1'b0;
        slave_val = 8'h3C;
        exp_frames.push_back({1'b0, 8'h05});
        exp_frames.push_back({1'b0, 8'h5A});
        exp_rsp.push_back({1'b0, 8'h00});
        exp_frames.push_back({1'b0, 8'h91});
        exp_frames.push_back({1'b1, 8'h91});
        exp_rsp.push_back({1'b0, 8'h3C});
        do_req(1'b0, 7'h05, 8'h5A);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid_seen", 32'(rsp_valid), 1);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 7'h11;
        req_wdata = 8'h00;
        repeat (50) begin
            @(negedge clk);
            check("bp_req_ready_low", 32'(req_ready), 0);
            check("bp_rsp_held", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b0, 8'h00}));
        end
        rsp_ready = 1'b1;
        do_req(1'b1, 7'h11, 8'h00);
        wait_idle();

        // CS never goes low: start timeout, no data frame
        master_en = 1'b0;
        exp_frames.push_back({1'b0, 8'h33});
        exp_rsp.push_back({1'b1, 8'h00});
        do_req(1'b0, 7'h33, 8'h77);
        n = 0;
        while (!spi_wr_cmd && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_wr_cmd_rise", 32'(spi_wr_cmd), 1);
        n = 0;
        while (!rsp_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), START_TO);
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_rdata", 32'(rsp_rdata), 0);
        wait_idle();
        master_en = 1'b1;

        // reset while the data frame is in progress
        slave_val = 8'h99;
        exp_frames.push_back({1'b0, 8'hC0});
        exp_frames.push_back({1'b1, 8'hC0});
        do_req(1'b1, 7'h40, 8'h00);
        n = 0;
        while (!spi_rd_cmd && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_rd_cmd_seen", 32'(spi_rd_cmd), 1);
        n = 0;
        while (spi_cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_cs_low", 32'(spi_cs), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_cmd", 32'(spi_wr_cmd), 0);
        check("rst_mid_rd_cmd", 32'(spi_rd_cmd), 0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_req_ready", 32'(req_ready), 1);
        n = 0;
        while (!spi_cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (GAP_CYC + 2) @(negedge clk);

        slave_val = 8'h5E;
        exp_frames.push_back({1'b0, 8'hAA});
        exp_frames.push_back({1'b1, 8'hAA});
        exp_rsp.push_back({1'b0, 8'h5E});
        do_req(1'b1, 7'h2A, 8'h00);
        wait_idle();

        repeat (10) @(negedge clk);
        check("frames_outstanding", 32'(exp_frames.size()), 0);
        check("rsp_outstanding", 32'(exp_rsp.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
